// File: rtl/cr_gray2bin_pipe.sv
// Pipelined Gray-to-binary decoder with a one-bit-step checker on accepted input words.
// Latency: pStages cycles from the acceptance cycle to B_Valid when never stalled; one word per cycle.
// Backpressure: per-stage valids with bubble collapsing; B/StepErr hold while B_Valid & !B_Ready.
module cr_gray2bin_pipe #(
    parameter int pWidth  = 4,
    parameter int pStages = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              G_Valid,
    output logic              G_Ready,
    input  logic [pWidth-1:0] G,
    output logic              B_Valid,
    input  logic              B_Ready,
    output logic [pWidth-1:0] B,
    output logic              StepErr
);

    // Illegal parameters reference a module that does not exist so the build stops.
    if (pWidth < 2) begin : g_bad_width
        cr_gray2bin_pipe_illegal_width u_bad_width ();
    end
    if (pStages < 1 || pStages > pWidth) begin : g_bad_stages
        cr_gray2bin_pipe_illegal_stages u_bad_stages ();
    end

    // S guards array sizes and the divide when the stage count is illegal.
    localparam int S = (pStages < 1) ? 1 : pStages;
    // Bits resolved per stage; the last stage takes whatever is left.
    localparam int K = (pWidth + S - 1) / S;

    // Number of MSBs already in binary form after n stages (the MSB is binary for free).
    function automatic int rdone(input int n);
        int r;
        r = n * K;
        if (r > pWidth) r = pWidth;
        if (r < 1) r = 1;
        return r;
    endfunction

    // Turn Gray bits into binary for the bits between rin and rout resolved MSBs,
    // walking downward so each bit sees its already-resolved upper neighbour.
    function automatic logic [pWidth-1:0] resolve(input logic [pWidth-1:0] w,
                                                  input int rin, input int rout);
        logic [pWidth-1:0] r;
        r = w;
        for (int i = pWidth - 2; i >= 0; i--) begin
            if (i <= pWidth - 1 - rin && i >= pWidth - rout) begin
                r[i] = r[i] ^ r[i+1];
            end
        end
        return r;
    endfunction

    logic [S-1:0]      vld;
    logic [S-1:0]      load;
    logic [pWidth-1:0] dat [S];
    logic              err [S];
    logic [pWidth-1:0] gprev;
    logic              have_prev;
    logic              room;
    logic              in_xfer;

    // Advance chain from the output backward: a stage may load when it is empty
    // or the stage after it will take its contents this cycle.
    always_comb begin
        room = B_Ready;
        load = '0;
        for (int j = S - 1; j >= 0; j--) begin
            load[j] = !vld[j] | room;
            room    = load[j];
        end
    end

    assign G_Ready = load[0] & !Rst;
    assign in_xfer = G_Valid & G_Ready;

    // Outputs are forced idle while reset is held so nothing in flight leaks out.
    assign B_Valid = vld[S-1] & !Rst;
    assign B       = Rst ? '0 : dat[S-1];
    assign StepErr = err[S-1] & !Rst;

    // Stage registers, step-check history, and synchronous reset of all of them.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            vld       <= '0;
            gprev     <= '0;
            have_prev <= 1'b0;
            for (int j = 0; j < S; j++) begin
                dat[j] <= '0;
                err[j] <= 1'b0;
            end
        end else begin
            if (in_xfer) begin
                gprev     <= G;
                have_prev <= 1'b1;
                dat[0]    <= resolve(G, rdone(0), rdone(1));
                err[0]    <= have_prev && ($countones(G ^ gprev) > 1);
            end
            if (load[0]) begin
                vld[0] <= in_xfer;
            end
            for (int j = 1; j < S; j++) begin
                if (load[j]) begin
                    vld[j] <= vld[j-1];
                    if (vld[j-1]) begin
                        dat[j] <= resolve(dat[j-1], rdone(j), rdone(j + 1));
                        err[j] <= err[j-1];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cr_gray2bin_pipe.sv
// Bench for cr_gray2bin_pipe: directed streams on a 4-bit/2-stage decoder and a
// random +-1 Gray walk on an 8-bit/3-stage decoder, checked by a scoreboard.
module tb_cr_gray2bin_pipe;

    typedef struct {
        logic [7:0] b;
        logic       err;
        int         t;
    } exp_t;

    logic clk;
    int   cyc;
    int   tests;
    int   fails;

    // DUT A: pWidth=4, pStages=2
    logic       ra, gva, gra, bva, bra, ea;
    logic [3:0] ga, ba;
    // DUT B: pWidth=8, pStages=3
    logic       rb, gvb, grb, bvb, brb, eb;
    logic [7:0] gb, bbo;

    exp_t qa[$];
    exp_t qb[$];
    logic       hpa, hpb;
    logic [7:0] gpa, gpb;
    bit         lat_a;
    bit         done_b;
    int         acc_a;
    int         flags_b;
    int         exp_flags_b;

    cr_gray2bin_pipe #(.pWidth(4), .pStages(2)) u_a (
        .Clk(clk), .Rst(ra), .G_Valid(gva), .G_Ready(gra), .G(ga),
        .B_Valid(bva), .B_Ready(bra), .B(ba), .StepErr(ea)
    );

    cr_gray2bin_pipe #(.pWidth(8), .pStages(3)) u_b (
        .Clk(clk), .Rst(rb), .G_Valid(gvb), .G_Ready(grb), .G(gb),
        .B_Valid(bvb), .B_Ready(brb), .B(bbo), .StepErr(eb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] enc(input int n);
        logic [7:0] v;
        v = n[7:0];
        return v ^ (v >> 1);
    endfunction

    // Reference decode: find the integer whose Gray encoding is g.
    function automatic logic [7:0] dec_ref(input int w, input logic [7:0] g);
        for (int m = 0; m < (1 << w); m++) begin
            if (enc(m) == g) return m[7:0];
        end
        return 8'hxx;
    endfunction

    // Send one word into DUT A; called just after a rising edge.
    task automatic put_a(input logic [3:0] g);
        int   n;
        exp_t e;
        gva = 1'b1;
        ga  = g;
        n   = 0;
        forever begin
            @(negedge clk);
            if (gra) break;
            n++;
            if (n > 100) begin
                check("a_accept_timeout", 32'd0, 32'd1);
                @(posedge clk); #1;
                gva = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        e.b   = dec_ref(4, {4'b0, g});
        e.err = hpa && ($countones({4'b0, g} ^ gpa) > 1);
        e.t   = cyc;
        hpa   = 1'b1;
        gpa   = {4'b0, g};
        qa.push_back(e);
        acc_a++;
        @(posedge clk); #1;
        gva = 1'b0;
    endtask

    // Send one word into DUT B after a random idle gap.
    task automatic put_b(input logic [7:0] g);
        int   n;
        exp_t e;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
        end
        gvb = 1'b1;
        gb  = g;
        n   = 0;
        forever begin
            @(negedge clk);
            if (grb) break;
            n++;
            if (n > 100) begin
                check("b_accept_timeout", 32'd0, 32'd1);
                @(posedge clk); #1;
                gvb = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        e.b   = dec_ref(8, g);
        e.err = hpb && ($countones(g ^ gpb) > 1);
        e.t   = cyc;
        if (e.err) exp_flags_b++;
        hpb   = 1'b1;
        gpb   = g;
        qb.push_back(e);
        @(posedge clk); #1;
        gvb = 1'b0;
    endtask

    task automatic drain(input string name, input bit which_b);
        int n;
        n = 0;
        while ((which_b ? qb.size() : qa.size()) != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, which_b ? qb.size() : qa.size(), 0);
    endtask

    // Output monitor A: pops the scoreboard on every output transfer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bva && bra) begin
                if (qa.size() == 0) begin
                    check("a_unexpected_output", {28'b0, ba}, 32'hFFFF_FFFF);
                end else begin
                    e = qa.pop_front();
                    check("a_data", {28'b0, ba}, {24'b0, e.b});
                    check("a_steperr", {31'b0, ea}, {31'b0, e.err});
                    if (lat_a) check("a_latency", cyc - e.t, 2);
                end
            end
        end
    end

    // Output monitor B.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bvb && brb) begin
                if (qb.size() == 0) begin
                    check("b_unexpected_output", {24'b0, bbo}, 32'hFFFF_FFFF);
                end else begin
                    e = qb.pop_front();
                    check("b_data", {24'b0, bbo}, {24'b0, e.b});
                    check("b_steperr", {31'b0, eb}, {31'b0, e.err});
                    if (eb) flags_b++;
                end
            end
        end
    end

    // Directed sequence on DUT A.
    task automatic run_a();
        logic [3:0] hold_b;
        logic       hold_e;
        bit         have_hold;
        int         acc0;

        // Streaming 0..15 and the 1000 -> 0000 wrap, full throughput, fixed latency.
        lat_a = 1'b1;
        bra   = 1'b1;
        for (int n = 0; n < 16; n++) put_a(enc(n)[3:0]);
        put_a(4'b0000);
        drain("a_drain_stream", 1'b0);
        lat_a = 1'b0;

        // Two-bit jump flagged on that word only.
        put_a(4'b0000);
        put_a(4'b0011);
        put_a(4'b0010);
        drain("a_drain_step", 1'b0);

        // Backpressure: five stalled cycles with continuous input.
        bra       = 1'b0;
        acc0      = acc_a;
        have_hold = 1'b0;
        hold_b    = '0;
        hold_e    = 1'b0;
        fork
            begin
                for (int n = 3; n < 9; n++) put_a(enc(n)[3:0]);
            end
            begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (bva) begin
                        if (!have_hold) begin
                            hold_b    = ba;
                            hold_e    = ea;
                            have_hold = 1'b1;
                        end else begin
                            check("a_stall_b_stable", {28'b0, ba}, {28'b0, hold_b});
                            check("a_stall_err_stable", {31'b0, ea}, {31'b0, hold_e});
                        end
                    end
                end
                check("a_stall_accepted", acc_a - acc0, 2);
                check("a_stall_g_ready", {31'b0, gra}, 32'd0);
                check("a_stall_b_valid", {31'b0, bva}, 32'd1);
                @(posedge clk); #1;
                bra = 1'b1;
            end
        join
        drain("a_drain_stall", 1'b0);

        // Reset with two words in flight.
        bra = 1'b0;
        put_a(4'b0101);
        put_a(4'b0100);
        ra = 1'b1;
        @(negedge clk);
        check("a_rst_g_ready", {31'b0, gra}, 32'd0);
        check("a_rst_b_valid", {31'b0, bva}, 32'd0);
        qa.delete();
        hpa = 1'b0;
        gpa = '0;
        @(posedge clk); #1;
        ra  = 1'b0;
        bra = 1'b1;
        @(negedge clk);
        check("a_postrst_b_valid", {31'b0, bva}, 32'd0);
        check("a_postrst_b", {28'b0, ba}, 32'd0);
        check("a_postrst_err", {31'b0, ea}, 32'd0);
        @(posedge clk); #1;
        put_a(4'b1111);
        drain("a_drain_rst", 1'b0);
    endtask

    // Random +-1 walk on DUT B with one three-bit jump.
    task automatic run_b();
        int         n;
        logic [7:0] g;
        n = $urandom_range(0, 255);
        for (int s = 0; s < 1000; s++) begin
            if (s == 500) begin
                g = enc(n) ^ 8'b1010_0100;
                n = dec_ref(8, g);
            end else begin
                n = ($urandom_range(0, 1) != 0) ? (n + 1) & 255 : (n + 255) & 255;
                g = enc(n);
            end
            put_b(g);
        end
        done_b = 1'b1;
        drain("b_drain", 1'b1);
        check("b_flag_count", flags_b, exp_flags_b);
        check("b_flag_expected_one", exp_flags_b, 1);
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0;
        hpa = 1'b0; hpb = 1'b0; gpa = '0; gpb = '0;
        lat_a = 1'b0; done_b = 1'b0; acc_a = 0; flags_b = 0; exp_flags_b = 0;
        ra = 1'b1; gva = 1'b0; ga = '0; bra = 1'b1;
        rb = 1'b1; gvb = 1'b0; gb = '0; brb = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("a_reset_g_ready", {31'b0, gra}, 32'd0);
        check("a_reset_b_valid", {31'b0, bva}, 32'd0);
        check("b_reset_g_ready", {31'b0, grb}, 32'd0);
        check("b_reset_b_valid", {31'b0, bvb}, 32'd0);
        @(posedge clk); #1;
        ra = 1'b0;
        rb = 1'b0;
        @(negedge clk);
        check("a_reset_b", {28'b0, ba}, 32'd0);
        check("a_reset_err", {31'b0, ea}, 32'd0);
        check("b_reset_b", {24'b0, bbo}, 32'd0);
        check("a_ready_after_reset", {31'b0, gra}, 32'd1);
        @(posedge clk); #1;

        fork
            run_a();
            run_b();
            begin
                while (!done_b) begin
                    @(posedge clk); #1;
                    brb = ($urandom_range(0, 3) != 0);
                end
                brb = 1'b1;
            end
        join

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cr_gray2bin_pipe.md
Name: cr_gray2bin_pipe

Overview:
Pipelined Gray-code to binary decoder with valid/ready handshakes on both sides. It is the inverse companion to the team's binary-to-Gray encoder.
Typical use: the receiving clock domain of CDC pointer paths and Gray-coded position/counter inputs.
It also checks that consecutive accepted Gray words differ by at most one bit, and flags any violation alongside the decoded word.

Parameters:
pWidth, 4, datapath width; pWidth < 2 is an elaboration error (instantiate a non-existent module, as in the encoder).
pStages, 1, pipeline depth (register stages) from input to output; legal range 1..pWidth; out of range is an elaboration error.

Ports:
Clk  input  1  clock; all logic rising-edge.
Rst  input  1  synchronous, active-high reset.
G_Valid  input  1  input word valid.
G_Ready  output  1  decoder can accept input this cycle.
G  input  pWidth  Gray-code input word.
B_Valid  output  1  output word valid.
B_Ready  input  1  downstream accepts output this cycle.
B  output  pWidth  decoded binary output word.
StepErr  output  1  sideband qualified by B_Valid; 1 = this word's Gray input differed from the previously accepted Gray input in more than one bit.

Behaviour:
- One clock (Clk). Reset is synchronous, active-high (Rst), sampled on the Clk rising edge.
- Transfer rules: input transfer when G_Valid & G_Ready; output transfer when B_Valid & B_Ready.
- Decode function: B[pWidth-1] = G[pWidth-1]; B[i] = B[i+1] ^ G[i] for i = pWidth-2 down to 0.
- Stage split:
  - MSB-first prefix XOR split across pStages stages, each resolving ceil(pWidth/pStages) bits; the last stage takes the remainder.
  - Each stage register carries the resolved binary MSBs so far, the unresolved Gray LSBs, the step-error bit, and a valid bit.
- Pipeline: per-stage valid with bubble collapsing.
  - A stage loads when it is empty or its contents advance this cycle.
  - G_Ready = !v[0] | advance[0]; the output stage advances when B_Ready.
  - Capacity is pStages words.
  - No combinational path from G_Valid to B_Valid.
  - G_Ready depends combinationally on B_Ready only through the advance chain.
- Latency: an accepted word appears at B, with B_Valid=1, exactly pStages cycles after its acceptance edge when never stalled.
- Throughput: one word per cycle with B_Ready held high.
- Backpressure: while B_Valid & !B_Ready, B and StepErr hold stable. Words are never dropped, duplicated or reordered.
- Step check:
  - A register Gprev and a flag HavePrev are updated on every input transfer.
  - The error bit for a word is (HavePrev & popcount(G ^ Gprev) > 1).
  - Zero-bit change (a repeated word) is legal.
  - All-ones to zero wrap encodings are checked like any other pair; e.g. pWidth=4: 1000 -> 0000 is a 1-bit step, legal.
  - The error bit travels with its word; it does not stick.
- Reset, while Rst=1 and on the following cycle:
  - All stage valids clear, so B_Valid=0.
  - B=0, StepErr=0.
  - HavePrev=0, Gprev=0.
  - G_Ready=0 while Rst=1.
- Reset mid-operation: in-flight words are discarded. The first word accepted after reset never flags StepErr.
- Simultaneous input and output transfer on a full pipeline: legal. The word shifts through and stays at full throughput.

Test Plan:
1. pWidth=4, pStages=2, B_Ready=1: stream Gray 0000,0001,0011,0010,0110,...,1000 (binary 0..15) with G_Valid held high -> B = 0..15 in order; first B_Valid 2 cycles after first accept, then one per cycle; StepErr=0 throughout, including the 1000 -> 0000 wrap.
2. pWidth=4, pStages=2: accept 0000 then 0011 -> outputs B=0000 with StepErr=0, then B=0010 with StepErr=1; the next input 0010 -> B=0011 with StepErr=0 (no stickiness).
3. Backpressure, pWidth=4, pStages=2: continuous G_Valid, B_Ready low for 5 cycles -> G_Ready drops after 2 words are buffered; B and StepErr are stable while stalled; on release all words arrive once, in order, at 1/cycle.
4. Reset mid-stream: pulse Rst for 1 cycle with 2 words in flight -> B_Valid=0, B=0, StepErr=0 the cycle after; in-flight words are never output; first post-reset word 1111 -> B=1010, StepErr=0.
5. pWidth=8, pStages=3, random legal ±1 walk of 1000 steps plus random G_Valid/B_Ready -> B matches the reference decode per word, in order, with StepErr=0; inject one 3-bit jump -> exactly that word is flagged.
6. Elaboration: pWidth=1 or pStages=0 or pStages>pWidth -> build fails.
